// File: rtl/change_dispenser.sv
// Change dispenser: latches paid-cost on start and streams the change out as
// greedy coins (DENOM_HI, DENOM_MID, 1), one per coin_ack handshake.
module change_dispenser #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned DENOM_HI  = 5,
  parameter int unsigned DENOM_MID = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] paid,
  input  logic [WIDTH-1:0] cost,
  input  logic             coin_ack,
  output logic             coin_valid,
  output logic [WIDTH-1:0] coin_value,
  output logic [WIDTH-1:0] change_total,
  output logic             busy,
  output logic             done,
  output logic             short
);

  localparam logic [WIDTH-1:0] CoinHi  = WIDTH'(DENOM_HI);
  localparam logic [WIDTH-1:0] CoinMid = WIDTH'(DENOM_MID);
  localparam logic [WIDTH-1:0] CoinOne = WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StDispense, StDone} state_e;

  state_e           state;
  logic [WIDTH-1:0] remaining;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] left;

  // Largest denomination that still fits in the remaining change.
  function automatic logic [WIDTH-1:0] pick_coin(input logic [WIDTH-1:0] rem);
    if (rem >= CoinHi) begin
      return CoinHi;
    end else if (rem >= CoinMid) begin
      return CoinMid;
    end else begin
      return CoinOne;
    end
  endfunction

  assign diff = paid - cost;
  // coin_value always mirrors pick_coin(remaining) while dispensing.
  assign left = remaining - coin_value;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      remaining    <= '0;
      change_total <= '0;
      coin_valid   <= 1'b0;
      coin_value   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      short        <= 1'b0;
    end else begin
      done  <= 1'b0;
      short <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            if (paid < cost) begin
              short        <= 1'b1;
              change_total <= '0;
            end else if (paid == cost) begin
              change_total <= '0;
              remaining    <= '0;
              state        <= StDone;
              busy         <= 1'b1;
              done         <= 1'b1;
            end else begin
              remaining    <= diff;
              change_total <= diff;
              coin_valid   <= 1'b1;
              coin_value   <= pick_coin(diff);
              busy         <= 1'b1;
              state        <= StDispense;
            end
          end
        end
        StDispense: begin
          if (coin_ack) begin
            remaining <= left;
            if (left == '0) begin
              coin_valid <= 1'b0;
              coin_value <= '0;
              done       <= 1'b1;
              state      <= StDone;
            end else begin
              coin_value <= pick_coin(left);
            end
          end
        end
        StDone: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          state      <= StIdle;
          busy       <= 1'b0;
          coin_valid <= 1'b0;
          coin_value <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Returns change for a vending transaction: takes a paid/cost pair, computes the change, and emits it as a stream of coins, one per handshake. Greedy denominations are DENOM_HI, DENOM_MID and 1.
- Sits downstream of the paid/cost comparison logic.
- Drives the coin-ejector interface, which acknowledges each coin.
- An underpayment is reported with a one-cycle flag instead of dispensing.

Parameters:
WIDTH, 4, bit width of paid, cost, change and coin values
DENOM_HI, 5, largest coin value (must be > DENOM_MID)
DENOM_MID, 2, middle coin value (must be > 1; smallest coin is fixed at 1)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; forces IDLE and all outputs to 0
start  input  1  request pulse; sampled only in IDLE
paid  input  WIDTH  amount inserted, unsigned, sampled with start
cost  input  WIDTH  item price, unsigned, sampled with start
coin_ack  input  1  ejector accepted current coin
coin_valid  output  1  a coin is being offered on coin_value
coin_value  output  WIDTH  value of offered coin (DENOM_HI, DENOM_MID or 1); 0 when coin_valid=0
change_total  output  WIDTH  latched paid-cost of current/last transaction
busy  output  1  state != IDLE
done  output  1  one-cycle pulse: transaction complete
short  output  1  one-cycle pulse: paid < cost, nothing dispensed

Behaviour:
Reset values (async, immediate): state=IDLE, remaining=0, change_total=0, coin_valid=0, coin_value=0, busy=0, done=0, short=0.

States: IDLE, DISPENSE, DONE. All outputs are derived from registers, with no combinational path from inputs to outputs.

IDLE, start=1 (sampled on the rising edge), one of three cases:
- paid < cost: stay IDLE, short=1 for exactly the next cycle, change_total=0.
- paid == cost: change_total=0, go to DONE (done=1 next cycle, no coins).
- paid > cost: remaining = change_total = paid - cost (WIDTH-bit, cannot underflow), go to DISPENSE. coin_valid=1 in the next cycle, so latency is 1 cycle.

DISPENSE:
- coin_valid=1.
- coin_value = DENOM_HI if remaining >= DENOM_HI; else DENOM_MID if remaining >= DENOM_MID; else 1.
- coin_value and coin_valid are held stable until coin_ack=1 at a rising edge.
- On ack: remaining -= coin_value.
  - If the result is 0: go to DONE, coin_valid=0 next cycle.
  - Otherwise: stay in DISPENSE with the recomputed coin_value next cycle. Back-to-back acks give one coin per cycle.

DONE: done=1 for one cycle, then return to IDLE unconditionally.

Ignored inputs:
- start is ignored in DISPENSE and DONE; it is not queued.
- coin_ack is ignored outside DISPENSE.
- short and done are never high simultaneously.

change_total: holds its value until the next accepted start or reset.

Reset mid-DISPENSE: the coin offer drops immediately (asynchronous), and the transaction is lost. No partial-change accounting is kept.

Sum invariant: the coin_values acked in a transaction sum exactly to change_total. Coin count is minimal for the default denominations.

Test Plan:
- paid=9, cost=2, start, coin_ack held 1 -> change_total=7; coins 5 then 2 on consecutive cycles; done pulse the cycle after the 2nd ack; busy drops the cycle after done.
- paid=12, cost=3, coin_ack held 1 -> coins 5,2,2, then done; paid=15, cost=0 -> coins 5,5,5, then done.
- paid=6, cost=6 -> no coin_valid ever; done=1 exactly one cycle after start; change_total=0.
- paid=3, cost=7 -> short=1 for one cycle, busy stays 0, no coin_valid, no done.
- paid=8, cost=0, coin_ack low for 3 cycles then high -> coin_valid=1 and coin_value=5 stable throughout the stall; a start pulse with paid=15 during the stall is ignored; remaining coins are 2 then 1.
- Reset asserted mid-stall while offering coin 5 -> all outputs 0 immediately; after release, a new start with paid=4, cost=1 yields coins 2,1 normally.
